// File: rtl/hazard_stall_controller_if.sv
// Control bundle between the decode/EX stages and the hazard stall controller.
// Optional perf counters appear only when HAZARD_PERF_CNT_EN is defined.
interface hazard_stall_controller_if
`ifdef HAZARD_PERF_CNT_EN
    #(parameter int CNT_W = 32)
`endif
    ;
    logic [4:0] id_rs;
    logic [4:0] id_rt;
    logic       id_uses_rt;
    logic       id_ex_mem_read;
    logic [4:0] id_ex_write_register;
    logic       ex_branch_taken;
    logic       ex_jump;
    logic       pc_write;
    logic       if_id_write;
    logic       if_id_flush;
    logic       id_ex_flush;
    logic       busy;
`ifdef HAZARD_PERF_CNT_EN
    logic [CNT_W-1:0] stall_cycles;
    logic [CNT_W-1:0] flush_events;
`endif

    modport master (
        output id_rs, id_rt, id_uses_rt, id_ex_mem_read, id_ex_write_register,
               ex_branch_taken, ex_jump,
        input  pc_write, if_id_write, if_id_flush, id_ex_flush, busy
`ifdef HAZARD_PERF_CNT_EN
        , input stall_cycles, flush_events
`endif
    );

    modport slave (
        input  id_rs, id_rt, id_uses_rt, id_ex_mem_read, id_ex_write_register,
               ex_branch_taken, ex_jump,
        output pc_write, if_id_write, if_id_flush, id_ex_flush, busy
`ifdef HAZARD_PERF_CNT_EN
        , output stall_cycles, flush_events
`endif
    );
endinterface

// File: rtl/hazard_stall_controller.sv
// Purpose: load-use stall and branch/jump flush sequencing for the 5-stage pipeline.
// Latency: outputs are combinational from state+inputs (zero cycles); state moves on the falling edge.
// Backpressure: none upstream; it is the stall source. HAZARD_PERF_CNT_EN adds saturating counters.
module hazard_stall_controller #(
    parameter int LOAD_STALL_CYCLES = 1,
    parameter int REDIRECT_CYCLES   = 1
`ifdef HAZARD_PERF_CNT_EN
    , parameter int CNT_W           = 32
`endif
) (
    input  logic                       clk,
    input  logic                       reset,
    hazard_stall_controller_if.slave   bus
);
    typedef enum logic [1:0] {
        RUN        = 2'd0,
        LOAD_STALL = 2'd1,
        REDIRECT   = 2'd2
    } state_t;

    localparam logic [2:0] LS_RELOAD = 3'(LOAD_STALL_CYCLES - 1);
    localparam logic [2:0] RD_RELOAD = 3'(REDIRECT_CYCLES - 1);

    state_t     r_state;
    state_t     w_next_state;
    logic [2:0] r_cnt;
    logic [2:0] w_next_cnt;
    logic       w_redirect;
    logic       w_load_use;
    logic       w_pc_write;
    logic       w_if_id_write;
    logic       w_if_id_flush;
    logic       w_id_ex_flush;

    assign w_redirect = bus.ex_branch_taken | bus.ex_jump;
    // $0 is hardwired zero, so a load targeting it is never a real producer.
    assign w_load_use = bus.id_ex_mem_read && (bus.id_ex_write_register != 5'd0) &&
                        ((bus.id_ex_write_register == bus.id_rs) ||
                         (bus.id_uses_rt && (bus.id_ex_write_register == bus.id_rt)));

    always_ff @(negedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= RUN;
            r_cnt   <= 3'd0;
        end else begin
            r_state <= w_next_state;
            r_cnt   <= w_next_cnt;
        end
    end

    always_comb begin
        w_next_state  = RUN;
        w_next_cnt    = 3'd0;
        w_pc_write    = 1'b1;
        w_if_id_write = 1'b1;
        w_if_id_flush = 1'b0;
        w_id_ex_flush = 1'b0;
        if (w_redirect) begin
            w_if_id_flush = 1'b1;
            w_id_ex_flush = 1'b1;
            if (RD_RELOAD != 3'd0) begin
                w_next_state = REDIRECT;
                w_next_cnt   = RD_RELOAD;
            end
        end else begin
            case (r_state)
                LOAD_STALL: begin
                    w_pc_write    = 1'b0;
                    w_if_id_write = 1'b0;
                    w_id_ex_flush = 1'b1;
                    if (r_cnt > 3'd1) begin
                        w_next_state = LOAD_STALL;
                        w_next_cnt   = r_cnt - 3'd1;
                    end
                end
                REDIRECT: begin
                    w_if_id_flush = 1'b1;
                    w_id_ex_flush = 1'b1;
                    if (r_cnt > 3'd1) begin
                        w_next_state = REDIRECT;
                        w_next_cnt   = r_cnt - 3'd1;
                    end
                end
                default: begin
                    // The spare encoding behaves exactly like RUN.
                    if (w_load_use) begin
                        w_pc_write    = 1'b0;
                        w_if_id_write = 1'b0;
                        w_id_ex_flush = 1'b1;
                        if (LS_RELOAD != 3'd0) begin
                            w_next_state = LOAD_STALL;
                            w_next_cnt   = LS_RELOAD;
                        end
                    end
                end
            endcase
        end
    end

    // Reset forces the idle value even while hazard inputs are still asserted.
    assign bus.pc_write    = reset ? w_pc_write    : 1'b1;
    assign bus.if_id_write = reset ? w_if_id_write : 1'b1;
    assign bus.if_id_flush = reset ? w_if_id_flush : 1'b0;
    assign bus.id_ex_flush = reset ? w_id_ex_flush : 1'b0;
    assign bus.busy        = (r_state == LOAD_STALL) || (r_state == REDIRECT);

`ifdef HAZARD_PERF_CNT_EN
    logic [CNT_W-1:0] r_stall_cycles;
    logic [CNT_W-1:0] r_flush_events;

    always_ff @(negedge clk or negedge reset) begin
        if (!reset) begin
            r_stall_cycles <= '0;
            r_flush_events <= '0;
        end else begin
            if (!bus.pc_write && (r_stall_cycles != '1))
                r_stall_cycles <= r_stall_cycles + CNT_W'(1);
            if (w_redirect && (r_flush_events != '1))
                r_flush_events <= r_flush_events + CNT_W'(1);
        end
    end

    assign bus.stall_cycles = r_stall_cycles;
    assign bus.flush_events = r_flush_events;
`endif
endmodule
